// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry, sample voter.
package uart_pkg;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} ustate_t;

  localparam int unsigned UART_DATA_BITS = 8;

  // Oversample counter positions: three mid-bit samples and the last count of a bit.
  localparam logic [3:0] UART_SMP_A    = 4'd7;
  localparam logic [3:0] UART_SMP_B    = 4'd8;
  localparam logic [3:0] UART_SMP_C    = 4'd9;
  localparam logic [3:0] UART_BIT_LAST = 4'd15;

  // 2-of-3 majority vote.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// Fractional-N tick generator: emits one-cycle ticks at an average rate of RATE
// per second from a CLK_HZ clock, with a phase reset to realign to a line edge.
module uart_baud_nco #(
  parameter int unsigned CLK_HZ = 25_000_000,
  parameter int unsigned RATE   = 153_600
) (
  input  logic clk,
  input  logic rst,
  input  logic phase_rst,
  output logic tick
);

  localparam logic [32:0] CLK_W  = 33'(CLK_HZ);
  localparam logic [32:0] RATE_W = 33'(RATE);

  if (RATE >= CLK_HZ) begin : g_rate_chk
    $error("uart_baud_nco: RATE must be below CLK_HZ");
  end

  logic [31:0] acc;
  logic [32:0] sum;

  // Next accumulator value before wrap.
  always_comb sum = {1'b0, acc} + RATE_W;

  // Wrap is folded into the add step so every clock advances the phase; the
  // tick period averages exactly CLK_HZ/RATE cycles with no extra wrap cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (phase_rst) begin
      acc  <= '0;
      tick <= 1'b0;
    end else if (sum >= CLK_W) begin
      acc  <= 32'(sum - CLK_W);
      tick <= 1'b1;
    end else begin
      acc  <= sum[31:0];
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: synchronizes the RX pin, oversamples 16x from an NCO,
// majority-votes each bit, and strobes out good bytes or framing errors.
module uart_rx #(
  parameter int unsigned CLK_HZ     = 25_000_000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int unsigned RATE  = BAUD * OVERSAMPLE;
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

  if (OVERSAMPLE != 16) begin : g_os_chk
    $error("uart_rx: OVERSAMPLE is fixed at 16");
  end
  if (RATE >= CLK_HZ) begin : g_rate_chk
    $error("uart_rx: BAUD*OVERSAMPLE must be below CLK_HZ");
  end

  logic                      rx_meta, rx_s, rx_s_q;
  logic                      os_tick;
  logic                      start_edge;
  logic                      decide, boundary;
  logic                      smp_a, smp_b, maj;
  logic [3:0]                cnt;
  logic [IDX_W-1:0]          bit_idx;
  logic [UART_DATA_BITS-1:0] shreg;
  ustate_t                   state;

  // Two-flop synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_q  <= rx_s;
    end
  end

  // Start edge and per-bit decision points.
  always_comb begin
    start_edge = (state == U_IDLE) && rx_s_q && !rx_s;
    decide     = os_tick && (cnt == UART_SMP_C);
    boundary   = os_tick && (cnt == UART_BIT_LAST);
    maj        = maj3(smp_a, smp_b, rx_s);
  end

  uart_baud_nco #(
    .CLK_HZ (CLK_HZ),
    .RATE   (RATE)
  ) u_nco (
    .clk       (clk),
    .rst       (rst),
    .phase_rst (start_edge),
    .tick      (os_tick)
  );

  // Oversample counter: restarts at the start edge, wraps 15->0 at each bit boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (start_edge) begin
      cnt <= '0;
    end else if (os_tick && state != U_IDLE) begin
      cnt <= cnt + 4'd1;
    end
  end

  // Latch the first two of the three mid-bit samples; the third is rx_s at decision time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_a <= 1'b1;
      smp_b <= 1'b1;
    end else if (os_tick) begin
      if (cnt == UART_SMP_A) smp_a <= rx_s;
      if (cnt == UART_SMP_B) smp_b <= rx_s;
    end
  end

  // Frame FSM: start validation, LSB-first data shift, stop-bit decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= U_IDLE;
      bit_idx  <= '0;
      shreg    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_busy  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (state)
        U_IDLE: begin
          if (start_edge) begin
            state   <= U_START;
            rx_busy <= 1'b1;
            bit_idx <= '0;
          end
        end
        U_START: begin
          if (decide && maj) begin
            state   <= U_IDLE;
            rx_busy <= 1'b0;
          end else if (boundary) begin
            state <= U_DATA;
          end
        end
        U_DATA: begin
          if (decide) begin
            shreg <= {maj, shreg[UART_DATA_BITS-1:1]};
          end
          if (boundary) begin
            if (bit_idx == IDX_LAST) state <= U_STOP;
            else                     bit_idx <= bit_idx + 1'b1;
          end
        end
        U_STOP: begin
          if (decide) begin
            if (maj) begin
              rx_data  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_ferr <= 1'b1;
            end
            rx_busy <= 1'b0;
            state   <= U_IDLE;
          end
        end
        default: state <= U_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a line-level TX model drives frames, expected receive
// events go into a scoreboard queue, and a monitor pops them as the DUT strobes.
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 25_000_000;
  localparam int unsigned BAUD   = 115_200;
  localparam int unsigned BIT_P  = 217;
  localparam int unsigned BIT_F  = 211;
  localparam int unsigned BIT_S  = 223;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ferr, rx_busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    int unsigned per;
    logic        stop;
    int unsigned gap;
  } vec_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] last_good;
  vec_t       vecs[5];

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .OVERSAMPLE (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_busy  (rx_busy)
  );

  always #20 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Pops one expected event per DUT strobe.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst && (rx_valid || rx_ferr)) begin
        chk("valid_ferr_exclusive", 32'(rx_valid & rx_ferr), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: valid=%0b ferr=%0b data=%0h, required no pulse",
                   rx_valid, rx_ferr, rx_data);
        end else begin
          mon_e = sb.pop_front();
          chk("ev_ferr", 32'(rx_ferr), 32'(mon_e.ferr));
          chk("ev_valid", 32'(rx_valid), 32'(!mon_e.ferr));
          chk("ev_data", 32'(rx_data), 32'(mon_e.ferr ? last_good : mon_e.data));
          if (!mon_e.ferr) last_good = mon_e.data;
        end
      end
    end
  endtask

  // Drive one 8N1 frame; optional 3-clk glitch inside bit 'glit'. Call at a negedge.
  task automatic send_byte(input logic [7:0] d, input int unsigned per,
                           input logic stop, input int glit);
    rx = 1'b0;
    wait_clk(per);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == 1) begin
        wait_clk(per / 2);
        chk("busy_mid_frame", 32'(rx_busy), 32'd1);
        wait_clk(per - per / 2);
      end else if (i == glit) begin
        wait_clk(118);
        rx = ~d[i];
        wait_clk(3);
        rx = d[i];
        wait_clk(per - 121);
      end else begin
        wait_clk(per);
      end
    end
    rx = stop;
    wait_clk(per);
    chk("busy_after_stop", 32'(rx_busy), 32'd0);
  endtask

  task automatic wait_drain(input int unsigned bound);
    int unsigned n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d events outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0]  rb;
    int unsigned rp;

    vecs[0] = '{data: 8'h55, per: BIT_P, stop: 1'b1, gap: 400};
    vecs[1] = '{data: 8'hA3, per: BIT_P, stop: 1'b1, gap: 400};
    vecs[2] = '{data: 8'h00, per: BIT_P, stop: 1'b1, gap: 0};
    vecs[3] = '{data: 8'hFF, per: BIT_P, stop: 1'b1, gap: 0};
    vecs[4] = '{data: 8'h80, per: BIT_P, stop: 1'b1, gap: 400};

    rst       = 1'b1;
    rx        = 1'b1;
    last_good = 8'h00;
    wait_clk(5);
    chk("rst_data", 32'(rx_data), 32'h00);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_ferr", 32'(rx_ferr), 32'd0);
    chk("rst_busy", 32'(rx_busy), 32'd0);
    rst = 1'b0;
    fork
      monitor();
    join_none
    wait_clk(20);
    chk("idle_busy", 32'(rx_busy), 32'd0);

    // Basic frames and zero-gap back-to-back frames.
    foreach (vecs[i]) begin
      sb.push_back('{ferr: !vecs[i].stop, data: vecs[i].data});
      send_byte(vecs[i].data, vecs[i].per, vecs[i].stop, -1);
      wait_clk(vecs[i].gap);
    end
    wait_drain(4000);

    // False start: 50-clk low pulse must abort silently.
    rx = 1'b0;
    wait_clk(50);
    rx = 1'b1;
    wait_clk(10);
    chk("false_start_busy_hi", 32'(rx_busy), 32'd1);
    wait_clk(300);
    chk("false_start_busy_lo", 32'(rx_busy), 32'd0);

    // Mid-bit glitch inside a frame is voted out.
    sb.push_back('{ferr: 1'b0, data: 8'h5A});
    send_byte(8'h5A, BIT_P, 1'b1, 3);
    wait_clk(300);
    wait_drain(4000);

    // Framing error followed by a held-low break: one ferr, nothing more.
    sb.push_back('{ferr: 1'b1, data: 8'h3C});
    send_byte(8'h3C, BIT_P, 1'b0, -1);
    wait_clk(20 * BIT_P);
    chk("break_busy", 32'(rx_busy), 32'd0);
    chk("break_data_held", 32'(rx_data), 32'h5A);
    wait_drain(10);
    rx = 1'b1;
    wait_clk(2 * BIT_P);

    // Reset in the middle of data bit 4 of 0xC3, then a clean 0x96.
    rb = 8'hC3;
    rx = 1'b0;
    wait_clk(BIT_P);
    for (int i = 0; i < 4; i++) begin
      rx = rb[i];
      wait_clk(BIT_P);
    end
    rx = rb[4];
    wait_clk(100);
    rst       = 1'b1;
    last_good = 8'h00;
    wait_clk(3);
    chk("midrst_busy", 32'(rx_busy), 32'd0);
    chk("midrst_data", 32'(rx_data), 32'h00);
    rx = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2 * BIT_P);
    chk("post_rst_busy", 32'(rx_busy), 32'd0);
    sb.push_back('{ferr: 1'b0, data: 8'h96});
    send_byte(8'h96, BIT_P, 1'b1, -1);
    wait_drain(4000);

    // Random bytes with the TX bit period at -3%, nominal, +3%.
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 2))
        0:       rp = BIT_F;
        1:       rp = BIT_S;
        default: rp = BIT_P;
      endcase
      sb.push_back('{ferr: 1'b0, data: rb});
      send_byte(rb, rp, 1'b1, -1);
      wait_clk($urandom_range(0, 3));
    end
    wait_drain(4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
